// File: rtl/ifetch_pkg.sv
// ifetch_pkg: constants shared by the fetch stage and the core controller.
//   npc_op_e  - 2-bit next-PC select codes (NPC_PC4/BR/JAL/JALR)
//   NOP_INST  - instruction held on inst after reset (addi x0,x0,0)
//   word_align() - clears bits [1:0] of an address
package ifetch_pkg;

   typedef enum logic [1:0] {
      NPC_PC4  = 2'd0,
      NPC_BR   = 2'd1,
      NPC_JAL  = 2'd2,
      NPC_JALR = 2'd3
   } npc_op_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_npc.sv
// ifetch_npc: combinational next-PC calculator.
//   i_pc       - current PC
//   i_npc_op   - next-PC select (npc_op_e)
//   i_br_taken - branch condition, only used with NPC_BR
//   i_imm_ext  - sign-extended branch/JAL offset
//   i_alu_c    - JALR target from the ALU
//   o_npc      - next PC, always word aligned, wraps mod 2^32
module ifetch_npc
   import ifetch_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [1:0]  i_npc_op,
   input  logic        i_br_taken,
   input  logic [31:0] i_imm_ext,
   input  logic [31:0] i_alu_c,
   output logic [31:0] o_npc
);

   logic [31:0] w_pc4;
   logic [31:0] w_pc_imm;
   logic [31:0] w_target;

   assign w_pc4    = i_pc + 32'd4;
   assign w_pc_imm = i_pc + i_imm_ext;

   always_comb begin
      w_target = w_pc4;
      case (npc_op_e'(i_npc_op))
         NPC_PC4:  w_target = w_pc4;
         NPC_BR:   w_target = i_br_taken ? w_pc_imm : w_pc4;
         NPC_JAL:  w_target = w_pc_imm;
         NPC_JALR: w_target = i_alu_c;
         default:  w_target = w_pc4;
      endcase
   end

   // No misalignment trap: low bits are simply dropped.
   assign o_npc = word_align(w_target);

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage. Owns the PC, fetches over a req/ack
// handshake with timeout/retry, and holds inst/pc/pc4 until step.
//   i_clk, i_rst       - clock, synchronous active-high reset
//   i_npc_op, i_br_taken, i_imm_ext, i_alu_c - next-PC controls
//   i_step             - advance to the next instruction (only when valid)
//   o_irom_req, o_irom_addr, i_irom_ack, i_irom_rdata - memory handshake
//   o_inst, o_pc, o_pc4, o_inst_valid - instruction to decode
//   o_fetch_err        - sticky: a fetch timed out since reset
//
// state   | meaning
// S_REQ   | request asserted at pc, waiting for ack (counting wait cycles)
// S_RETRY | one idle cycle after a timeout, then re-request same pc
// S_VALID | instruction held for decode, waiting for step
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ACK_TIMEOUT = 16
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_npc_op,
   input  logic        i_br_taken,
   input  logic [31:0] i_imm_ext,
   input  logic [31:0] i_alu_c,
   input  logic        i_step,
   output logic        o_irom_req,
   output logic [31:0] o_irom_addr,
   input  logic        i_irom_ack,
   input  logic [31:0] i_irom_rdata,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc4,
   output logic        o_inst_valid,
   output logic        o_fetch_err
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_RETRY = 2'd1,
      S_VALID = 2'd2
   } state_e;

   localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

   state_e      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        r_inst_valid;
   logic        r_fetch_err;
   logic [7:0]  r_wait_cnt;
   logic [31:0] w_npc;

   ifetch_npc u_npc (
      .i_pc       (r_pc),
      .i_npc_op   (i_npc_op),
      .i_br_taken (i_br_taken),
      .i_imm_ext  (i_imm_ext),
      .i_alu_c    (i_alu_c),
      .o_npc      (w_npc)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_REQ;
         r_pc         <= word_align(RESET_PC);
         r_inst       <= NOP_INST;
         r_inst_valid <= 1'b0;
         r_fetch_err  <= 1'b0;
         r_wait_cnt   <= 8'd0;
      end else begin
         case (r_state)
            S_REQ: begin
               if (i_irom_ack) begin
                  r_inst       <= i_irom_rdata;
                  r_inst_valid <= 1'b1;
                  r_state      <= S_VALID;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_fetch_err <= 1'b1;
                  r_wait_cnt  <= 8'd0;
                  r_state     <= S_RETRY;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            // Any ack arriving here belongs to the abandoned request.
            S_RETRY: r_state <= S_REQ;
            S_VALID: begin
               if (i_step) begin
                  r_pc         <= w_npc;
                  r_inst_valid <= 1'b0;
                  r_wait_cnt   <= 8'd0;
                  r_state      <= S_REQ;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

   assign o_irom_req   = (r_state == S_REQ);
   assign o_irom_addr  = r_pc;
   assign o_inst       = r_inst;
   assign o_pc         = r_pc;
   assign o_pc4        = r_pc + 32'd4;
   assign o_inst_valid = r_inst_valid;
   assign o_fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
   import ifetch_pkg::*;

   localparam int          TO  = 8;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, br_taken, step, ack;
   logic [1:0]  npc_op;
   logic [31:0] imm_ext, alu_c, rdata;
   logic        irom_req, inst_valid, fetch_err;
   logic [31:0] irom_addr, inst, pc, pc4;

   int n_err = 0;
   int n_chk = 0;

   // reference model: architectural view of the fetch stage
   logic [31:0] m_pc, m_inst;
   logic        m_valid, m_err, m_retry;
   int          m_wait;

   always #5 clk = ~clk;

   ifetch #(.RESET_PC(RPC), .ACK_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_npc_op(npc_op), .i_br_taken(br_taken),
      .i_imm_ext(imm_ext), .i_alu_c(alu_c), .i_step(step),
      .o_irom_req(irom_req), .o_irom_addr(irom_addr), .i_irom_ack(ack),
      .i_irom_rdata(rdata), .o_inst(inst), .o_pc(pc), .o_pc4(pc4),
      .o_inst_valid(inst_valid), .o_fetch_err(fetch_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_npc(input logic [1:0] op, input logic [31:0] p,
                                          input logic br, input logic [31:0] imm,
                                          input logic [31:0] alu);
      logic [31:0] t;
      case (op)
         2'd0:    t = p + 4;
         2'd1:    t = br ? p + imm : p + 4;
         2'd2:    t = p + imm;
         default: t = alu;
      endcase
      t[1:0] = 2'b00;
      return t;
   endfunction

   task automatic model_update();
      if (rst) begin
         m_pc = RPC; m_inst = 32'h0000_0013; m_valid = 0; m_err = 0;
         m_wait = 0; m_retry = 0;
      end else if (m_retry) begin
         m_retry = 0;
      end else if (m_valid) begin
         if (step) begin
            m_pc = ref_npc(npc_op, m_pc, br_taken, imm_ext, alu_c);
            m_valid = 0; m_wait = 0;
         end
      end else if (ack) begin
         m_inst = rdata; m_valid = 1;
      end else if (m_wait == TO - 1) begin
         m_err = 1; m_wait = 0; m_retry = 1;
      end else begin
         m_wait++;
      end
   endtask

   task automatic compare_all();
      logic m_req;
      m_req = !m_valid && !m_retry;
      chk("req", 32'(irom_req), 32'(m_req));
      if (m_req) chk("addr", irom_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc4", pc4, m_pc + 4);
      chk("inst", inst, m_inst);
      chk("valid", 32'(inst_valid), 32'(m_valid));
      chk("err", 32'(fetch_err), 32'(m_err));
   endtask

   // drive inputs for one cycle, advance the model, sample on the next negedge
   task automatic tick(input logic r, input logic [1:0] op, input logic br,
                       input logic [31:0] imm, input logic [31:0] alu,
                       input logic st, input logic a, input logic [31:0] d);
      rst = r; npc_op = op; br_taken = br; imm_ext = imm; alu_c = alu;
      step = st; ack = a; rdata = d;
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic go(input logic [1:0] op, input logic br, input logic [31:0] imm,
                     input logic [31:0] alu);
      tick(0, op, br, imm, alu, 1, 0, 32'h0);
   endtask

   task automatic fetch(input logic [31:0] d);
      tick(0, NPC_PC4, 0, 0, 0, 0, 1, d);
   endtask

   initial begin
      int req_cnt;
      tick(1, NPC_PC4, 0, 0, 0, 0, 0, 0);
      tick(1, NPC_PC4, 0, 0, 0, 0, 1, 32'h0010_0093);
      chk("rst_req", 32'(irom_req), 1);
      chk("rst_addr", irom_addr, 0);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_valid", 32'(inst_valid), 0);
      chk("rst_err", 32'(fetch_err), 0);
      tick(0, NPC_PC4, 0, 0, 0, 0, 1, 32'h0010_0093);
      chk("first_inst", inst, 32'h0010_0093);
      chk("first_valid", 32'(inst_valid), 1);
      chk("first_pc4", pc4, 4);

      // to 0x8, then sequential fetch with 3 wait cycles
      go(NPC_JAL, 0, 8, 0);
      fetch(32'h1111_0001);
      go(NPC_PC4, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("seq_addr_hold", irom_addr, 32'hC);
         tick(0, NPC_PC4, 0, 0, 0, 0, 0, 0);
      end
      chk("seq_addr_hold", irom_addr, 32'hC);
      fetch(32'h2222_0002);
      chk("seq_valid", 32'(inst_valid), 1);

      // control flow
      go(NPC_JAL, 0, 4, 0);            // 0x10
      fetch(32'h3);
      go(NPC_BR, 1, 32'hFFFF_FFF8, 0);
      chk("br_taken", pc, 32'h08);
      fetch(32'h4);
      go(NPC_JAL, 0, 8, 0);            // 0x10
      fetch(32'h5);
      go(NPC_BR, 0, 32'hFFFF_FFF8, 0);
      chk("br_not_taken", pc, 32'h14);
      fetch(32'h6);
      go(NPC_JALR, 0, 0, 32'h103);
      chk("jalr_align", pc, 32'h100);
      fetch(32'h7);

      // timeout and retry at 0x104
      go(NPC_PC4, 0, 0, 0);
      req_cnt = 0;
      for (int i = 0; i < TO; i++) begin
         if (irom_req) req_cnt++;
         tick(0, NPC_PC4, 0, 0, 0, 0, 0, 0);
      end
      chk("to_req_cycles", 32'(req_cnt), TO);
      chk("to_req_low", 32'(irom_req), 0);
      chk("to_err", 32'(fetch_err), 1);
      tick(0, NPC_PC4, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);   // late ack dropped
      chk("retry_req", 32'(irom_req), 1);
      chk("retry_addr", irom_addr, 32'h104);
      chk("retry_valid", 32'(inst_valid), 0);
      tick(0, NPC_JAL, 0, 32'h100, 0, 1, 0, 0);          // step while requesting
      chk("step_in_req", pc, 32'h104);
      fetch(32'h8);

      // wrap
      go(NPC_JALR, 0, 0, 32'hFFFF_FFFC);
      fetch(32'h9);
      chk("wrap_pc4", pc4, 0);
      go(NPC_PC4, 0, 0, 0);
      chk("wrap_pc", pc, 0);

      // reset with ack and step mid-wait
      tick(0, NPC_PC4, 0, 0, 0, 0, 0, 0);
      tick(1, NPC_JAL, 0, 32'h40, 0, 1, 1, 32'hABCD_0000);
      chk("rst_ack_pc", pc, RPC);
      chk("rst_ack_valid", 32'(inst_valid), 0);
      chk("rst_ack_err", 32'(fetch_err), 0);

      // randomized
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 63) == 0, 2'($urandom_range(0, 3)), 1'($urandom),
              $urandom, $urandom, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction-fetch stage of the miniRV core. Sits directly upstream of the decode stage.
- Owns the PC register and next-PC selection, and fetches each instruction from an instruction memory over a req/ack handshake.
- Holds the fetched instruction, pc and pc4 stable for decode/execute until the core signals commit.
- Allows the core to move from a combinational IROM to wait-state memory without changing decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- ACK_TIMEOUT, 16, cycles to wait for irom_ack before abandoning and reissuing the request (legal range 2..255)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- npc_op  in  2  next-PC select: NPC_PC4, NPC_BR, NPC_JAL, NPC_JALR
- br_taken  in  1  branch condition from ALU, used only with NPC_BR
- imm_ext  in  32  sign-extended immediate from decode (branch/JAL offset)
- alu_c  in  32  ALU result, the JALR target
- step  in  1  core has finished executing the current instruction; advance the PC
- irom_req  out  1  fetch request
- irom_addr  out  32  fetch address, always word aligned
- irom_ack  in  1  memory returns data this cycle
- irom_rdata  in  32  instruction word, valid when irom_ack=1
- inst  out  32  current instruction to decode
- pc  out  32  address of inst
- pc4  out  32  pc+4, the link value for decode write-back
- inst_valid  out  1  inst/pc/pc4 are valid
- fetch_err  out  1  sticky flag: at least one timeout has occurred since reset

Behaviour:
- Clock and reset:
  - Single clock domain; clk is the only clock.
  - Reset is synchronous and active-high on rst; it overrides every other input in that cycle.
- Reset values:
  - pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, fetch_err=0, wait counter=0, state=S_REQ.
  - irom_req is a decode of state, so it is 1 in the first cycle after reset.
- State machine (local encoding):
  - S_REQ:
    - irom_req=1, irom_addr=pc.
    - If irom_ack: inst<=irom_rdata, inst_valid<=1, go to S_VALID. Zero-wait ack in the same cycle is legal, giving 1-cycle fetch latency.
    - Else: counter++.
    - When counter reaches ACK_TIMEOUT-1 with no ack: fetch_err<=1, counter<=0, go to S_RETRY.
  - S_RETRY: irom_req=0 for exactly one cycle, then return to S_REQ with the same pc.
  - S_VALID:
    - irom_req=0, inst_valid=1.
    - If step: pc<=npc, inst_valid<=0, counter<=0, go to S_REQ.
- Handshake rules:
  - irom_addr is held stable while irom_req=1.
  - irom_ack is ignored in S_RETRY and S_VALID; a late ack after a timeout is discarded.
  - step is ignored unless inst_valid=1.
  - pc4 is always pc+4, combinational from the pc register.
- npc (combinational, 32-bit, wraps mod 2^32):
  - NPC_PC4: pc+4.
  - NPC_BR: br_taken ? pc+imm_ext : pc+4.
  - NPC_JAL: pc+imm_ext.
  - NPC_JALR: alu_c.
  - In every case bits[1:0] are forced to 2'b00. There is no misalignment trap.
  - Worked values: 32'hFFFF_FFFC with NPC_PC4 wraps to 0; pc4 at that pc is 0.
- Boundary conditions:
  - rst in the same cycle as irom_ack or step: reset wins and the ack data is dropped.
  - step held high continuously: one instruction per fetch round trip; no double advance.
  - inst holds its last value while inst_valid=0; decode must qualify with inst_valid.
  - fetch_err is cleared only by rst.

Decomposition:
- The NPC_* opcode constants (2-bit) go into the shared defines.vh next to the WB_* codes, so the controller and ifetch agree.
- The NOP constant 32'h0000_0013 also goes into defines.vh.
- State encoding stays local to the module.
- One sub-module: npc, the combinational next-PC calculator (inputs pc, npc_op, br_taken, imm_ext, alu_c; output npc). It is instantiated in ifetch and unit-testable alone.

Test Plan:
- Reset release with irom_ack tied 1, irom_rdata=32'h0010_0093 → cycle 1: irom_req=1, irom_addr=0. Cycle 2: inst_valid=1, inst=32'h0010_0093, pc=0, pc4=4.
- Sequential: step pulsed with NPC_PC4 at pc=0x8 and memory ack after 3 wait cycles → irom_addr=0xC held for all 4 request cycles; inst_valid returns 1 cycle after ack.
- Control flow:
  - pc=0x10, NPC_BR, br_taken=1, imm_ext=32'hFFFF_FFF8 → next pc=0x08.
  - Same with br_taken=0 → next pc=0x14.
  - NPC_JALR with alu_c=0x103 → next pc=0x100.
- Timeout with ACK_TIMEOUT=8, no ack → req high 8 cycles, fetch_err=1, req low 1 cycle, then req reissued at the same address. A late ack during S_RETRY is ignored.
- Wrap: pc=32'hFFFF_FFFC, NPC_PC4, step → pc=0; pc4 at that pc reads 0.
- Abuse:
  - step asserted during S_REQ → no PC change.
  - rst asserted together with ack and step mid-wait → pc=RESET_PC, inst_valid=0, fetch_err=0 next cycle.
